// File: rtl/mmio_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_if
// Description : CPU data-bus bundle between the load/store master and the
//               memory-mapped timer. The CPU drives MemWrite/DataAdr/
//               WriteData; the peripheral returns ReadData and its Sel.
// Ports       : MemWrite  - write strobe
//               DataAdr   - byte address
//               WriteData - store data
//               ReadData  - combinational read data (0 when not selected)
//               Sel       - address falls inside the peripheral window
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_timer_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Sel;

    modport master (
        output MemWrite, DataAdr, WriteData,
        input  ReadData, Sel
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData,
        output ReadData, Sel
    );
endinterface
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Memory-mapped prescaled 32-bit up-counter with compare match,
//               optional auto-reload and level interrupt. Decodes a 256-byte
//               window at BASE_ADDR; reads are combinational, writes take
//               effect on the rising clock edge.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-low reset
//               bus        - CPU data bus (slave side)
//               Irq        - level interrupt, MATCH & IRQ_EN
//               capture_in - asynchronous capture strobe
// Options     : MMIO_TIMER_CAPTURE_EN - adds synchronised capture of COUNT on
//               a capture_in rising edge (register 0x14). Without it 0x14
//               reads 0 and capture_in is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mmio_timer_if.slave   bus,
    output logic          Irq,
    input  wire logic     capture_in
);

    // Word indices (DataAdr[7:2]) of the register map
    localparam logic [5:0] c_IDX_CTRL     = 6'h00;
    localparam logic [5:0] c_IDX_COUNT    = 6'h01;
    localparam logic [5:0] c_IDX_COMPARE  = 6'h02;
    localparam logic [5:0] c_IDX_STATUS   = 6'h03;
    localparam logic [5:0] c_IDX_PRESCALE = 6'h04;
    localparam logic [5:0] c_IDX_CAPTURE  = 6'h05;

    logic        w_sel, w_wr, w_tick, w_hit, w_unused_ok;
    logic [5:0]  w_idx;
    logic [31:0] w_capture;

    logic        en_q, en_d, auto_q, auto_d, irqen_q, irqen_d, match_q, match_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic [15:0] prescale_q, prescale_d, pcnt_q, pcnt_d;

    assign w_sel   = (bus.DataAdr[31:8] == BASE_ADDR[31:8]);
    assign w_idx   = bus.DataAdr[7:2];
    assign w_wr    = w_sel & bus.MemWrite;
    assign bus.Sel = w_sel;

    // Tick fires on the cycle pcnt reaches PRESCALE; a compare hit is only
    // evaluated on a tick.
    assign w_tick = en_q & (pcnt_q == prescale_q);
    assign w_hit  = w_tick & (count_q == compare_q);

    assign Irq = match_q & irqen_q;

    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irqen_d    = irqen_q;
        compare_d  = compare_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        match_d    = match_q;
        pcnt_d     = pcnt_q;

        // Prescaler: held at 0 while disabled, wraps to 0 on each tick
        if (!en_q || w_tick) begin
            pcnt_d = 16'd0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        if (w_tick) begin
            count_d = (w_hit && auto_q) ? 32'd0 : count_q + 32'd1;
        end

        if (w_wr) begin
            unique case (w_idx)
                c_IDX_CTRL: begin
                    en_d    = bus.WriteData[0];
                    auto_d  = bus.WriteData[1];
                    irqen_d = bus.WriteData[2];
                end
                c_IDX_COUNT:    count_d   = bus.WriteData;
                c_IDX_COMPARE:  compare_d = bus.WriteData;
                c_IDX_STATUS: begin
                    if (bus.WriteData[0]) begin
                        match_d = 1'b0;
                    end
                end
                c_IDX_PRESCALE: begin
                    prescale_d = bus.WriteData[15:0];
                    pcnt_d     = 16'd0;
                end
                default: ;
            endcase
        end

        // Hardware set wins over a same-cycle write-1-clear
        if (w_hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irqen_q    <= 1'b0;
            match_q    <= 1'b0;
            count_q    <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            prescale_q <= 16'd0;
            pcnt_q     <= 16'd0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irqen_q    <= irqen_d;
            match_q    <= match_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end

`ifdef MMIO_TIMER_CAPTURE_EN
    // Two-flop synchroniser plus one history flop for edge detection; the
    // capture register samples the pre-edge COUNT, so same-cycle writes or
    // ticks never leak into the captured value.
    logic        sync1_q, sync2_q, sync3_q;
    logic [31:0] capture_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            capture_q <= 32'd0;
        end else begin
            sync1_q <= capture_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (sync2_q && !sync3_q) begin
                capture_q <= count_q;
            end
        end
    end

    assign w_capture   = capture_q;
    assign w_unused_ok = ^bus.DataAdr[1:0];
`else
    assign w_capture   = 32'd0;
    assign w_unused_ok = ^{bus.DataAdr[1:0], capture_in};
`endif

    always_comb begin
        bus.ReadData = 32'd0;
        if (w_sel) begin
            unique case (w_idx)
                c_IDX_CTRL:     bus.ReadData = {29'd0, irqen_q, auto_q, en_q};
                c_IDX_COUNT:    bus.ReadData = count_q;
                c_IDX_COMPARE:  bus.ReadData = compare_q;
                c_IDX_STATUS:   bus.ReadData = {31'd0, match_q};
                c_IDX_PRESCALE: bus.ReadData = {16'd0, prescale_q};
                c_IDX_CAPTURE:  bus.ReadData = w_capture;
                default:        bus.ReadData = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_timer
// Description : Self-checking bench for mmio_timer. Directed phases (reset,
//               prescale, compare/auto-reload, wrap/priority, capture, async
//               reset) followed by random bus traffic, all compared against
//               a behavioural timer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset;
    logic capture_in;
    logic Irq;

    mmio_timer_if bus();

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .Irq        (Irq),
        .capture_in (capture_in)
    );

    always #5 clk = ~clk;

    // Behavioural model: ticks are derived from the number of enabled cycles
    // elapsed since enable / prescale reload, taken modulo (PRESCALE+1).
    bit          m_en, m_auto, m_irqen, m_match;
    logic [31:0] m_count, m_cmp, m_cap;
    logic [15:0] m_pre;
    int unsigned m_elapsed;
    logic [2:0]  m_hist;   // capture_in as sampled at the last three edges

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_irqen = 0; m_match = 0;
        m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_cap = 32'd0;
        m_pre = 16'd0; m_elapsed = 0; m_hist = 3'b000;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:8] != BASE[31:8]) return 32'd0;
        case (a[7:0] & 8'hFC)
            8'h00:   return {29'd0, m_irqen, m_auto, m_en};
            8'h04:   return m_count;
            8'h08:   return m_cmp;
            8'h0C:   return {31'd0, m_match};
            8'h10:   return {16'd0, m_pre};
            8'h14:   return m_cap;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock edge: model next state from the currently driven bus.
    task automatic cycle();
        bit          wr, tick, hit, n_en, n_auto, n_irqen, n_match;
        logic [7:0]  off;
        logic [31:0] n_count, n_cmp, n_cap;
        logic [15:0] n_pre;
        int unsigned p, n_el;
        logic [2:0]  n_hist;
        wr   = bus.MemWrite && (bus.DataAdr[31:8] == BASE[31:8]);
        off  = bus.DataAdr[7:0] & 8'hFC;
        p    = m_pre;
        tick = m_en && ((m_elapsed % (p + 1)) == p);
        hit  = tick && (m_count == m_cmp);
        n_en = m_en; n_auto = m_auto; n_irqen = m_irqen; n_cmp = m_cmp; n_pre = m_pre;
        n_count = tick ? ((hit && m_auto) ? 32'd0 : m_count + 32'd1) : m_count;
        n_match = m_match;
        n_el    = m_en ? m_elapsed + 1 : 0;
        if (wr) begin
            case (off)
                8'h00: begin n_en = bus.WriteData[0]; n_auto = bus.WriteData[1]; n_irqen = bus.WriteData[2]; end
                8'h04: n_count = bus.WriteData;
                8'h08: n_cmp = bus.WriteData;
                8'h0C: if (bus.WriteData[0]) n_match = 0;
                8'h10: begin n_pre = bus.WriteData[15:0]; n_el = 0; end
                default: ;
            endcase
        end
        if (hit) n_match = 1;
        n_cap  = m_cap;
        n_hist = m_hist;
`ifdef MMIO_TIMER_CAPTURE_EN
        if (m_hist[1] && !m_hist[2]) n_cap = m_count;
        n_hist = {m_hist[1:0], capture_in};
`endif
        @(posedge clk);
        #1;
        m_en = n_en; m_auto = n_auto; m_irqen = n_irqen; m_match = n_match;
        m_count = n_count; m_cmp = n_cmp; m_pre = n_pre; m_elapsed = n_el;
        m_cap = n_cap; m_hist = n_hist;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = BASE | {24'd0, off};
        bus.WriteData = data;
        cycle();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] addr);
        bus.MemWrite = 1'b0;
        bus.DataAdr  = addr;
        #1;
        check(tag, bus.ReadData, model_read(addr));
    endtask

    task automatic chk_irq(input string tag);
        check(tag, {31'd0, Irq}, {31'd0, m_match && m_irqen});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_cap, r, addr, data;
        logic [7:0]  off;
        reset = 1'b0; capture_in = 1'b0;
        bus.MemWrite = 1'b0; bus.DataAdr = 32'd0; bus.WriteData = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset defaults
        chk_rd("rst_ctrl", BASE | 32'h00);
        check("rst_ctrl_const", bus.ReadData, 32'd0);
        chk_rd("rst_compare", BASE | 32'h08);
        check("rst_compare_const", bus.ReadData, 32'hFFFF_FFFF);
        chk_rd("rst_status", BASE | 32'h0C);
        check("rst_irq", {31'd0, Irq}, 32'd0);
        bus.DataAdr = BASE + 32'h100;
        #1;
        check("outside_sel", {31'd0, bus.Sel}, 32'd0);
        check("outside_rdata", bus.ReadData, 32'd0);

        // Prescaled counting
        wr(8'h10, 32'h55AA_1234);
        chk_rd("prescale_trunc", BASE | 32'h10);
        check("prescale_trunc_const", bus.ReadData, 32'h0000_1234);
        wr(8'h10, 32'd3);
        wr(8'h00, 32'd1);
        repeat (40) cycle();
        chk_rd("presc_count", BASE | 32'h04);
        check("presc_count_const", bus.ReadData, 32'd10);

        // Compare with auto-reload and interrupt
        wr(8'h00, 32'd0);
        wr(8'h04, 32'd0);
        wr(8'h08, 32'd5);
        wr(8'h10, 32'd0);
        wr(8'h0C, 32'd1);
        wr(8'h00, 32'd7);
        for (int i = 0; i < 6; i++) begin
            chk_rd("cmp_count", BASE | 32'h04);
            chk_irq("cmp_irq");
            cycle();
        end
        chk_rd("cmp_reload_count", BASE | 32'h04);
        check("cmp_reload_const", bus.ReadData, 32'd0);
        chk_rd("cmp_match", BASE | 32'h0C);
        check("cmp_irq_const", {31'd0, Irq}, 32'd1);
        wr(8'h00, 32'd6);
        wr(8'h0C, 32'd1);
        chk_rd("clr_status", BASE | 32'h0C);
        check("clr_irq_const", {31'd0, Irq}, 32'd0);

        // Wrap and priorities
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h08, 32'd50);
        wr(8'h00, 32'd1);
        cycle();
        chk_rd("wrap_count", BASE | 32'h04);
        check("wrap_const", bus.ReadData, 32'd0);
        wr(8'h04, 32'd100);
        chk_rd("wr_over_tick", BASE | 32'h04);
        check("wr_over_tick_const", bus.ReadData, 32'd100);
        wr(8'h08, 32'd102);
        cycle();
        chk_rd("pre_hit_status", BASE | 32'h0C);
        wr(8'h0C, 32'd1);
        chk_rd("set_beats_clr", BASE | 32'h0C);
        check("set_beats_clr_const", bus.ReadData, 32'd1);
        chk_irq("irq_masked");

        // Capture
`ifdef MMIO_TIMER_CAPTURE_EN
        capture_in = 1'b1;
        cycle();
        cycle();
        capture_in = 1'b0;
        exp_cap = m_count;
        cycle();
        chk_rd("capture", BASE | 32'h14);
        check("capture_const", bus.ReadData, exp_cap);
`else
        capture_in = 1'b1;
        repeat (4) cycle();
        capture_in = 1'b0;
        chk_rd("capture_off", BASE | 32'h14);
        check("capture_off_const", bus.ReadData, 32'd0);
`endif

        // Asynchronous reset mid-operation
        wr(8'h00, 32'd0);
        wr(8'h04, 32'd7);
        wr(8'h08, 32'd7);
        wr(8'h0C, 32'd1);
        wr(8'h00, 32'd5);
        cycle();
        wr(8'h00, 32'd4);
        wr(8'h04, 32'd7);
        chk_rd("pre_reset_count", BASE | 32'h04);
        check("pre_reset_irq", {31'd0, Irq}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", bus.ReadData, 32'd0);
        check("async_rst_irq", {31'd0, Irq}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) cycle();
        chk_rd("post_reset_count", BASE | 32'h04);

        // Random bus traffic
        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            addr = (r[2:0] == 3'd0) ? (32'h0000_1000 | {24'd0, r[15:8]}) : (BASE | {24'd0, r[15:8] & 8'h1F});
            addr[1:0] = r[17:16];
            chk_rd("rand_read", addr);
            check("rand_sel", {31'd0, bus.Sel}, {31'd0, addr[31:8] == BASE[31:8]});
            chk_irq("rand_irq");
            capture_in = r[20];
            if (r[24]) begin
                r = $urandom;
                off = {3'd0, r[4:2], 2'b00};
                data = $urandom;
                if (off == 8'h04 || off == 8'h08) data = $urandom_range(0, 15);
                if (off == 8'h10) data = {data[31:16], 14'd0, data[1:0]};
                bus.MemWrite  = 1'b1;
                bus.DataAdr   = (r[7:5] == 3'd0) ? (BASE + 32'h100 + {24'd0, off}) : (BASE | {24'd0, off});
                bus.WriteData = data;
            end
            cycle();
            bus.MemWrite = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
